mem_write_scoreboard: RTL and testbench
=======================================

Name: mem_write_scoreboard

Overview:
- Synthesizable, parametrised monitor on the processor data-memory write port (MemWrite, DataAdr, WriteData).
- Checks an in-order sequence of expected stores held in an internal table and enforces a cycle watchdog.
- Reports pass/fail/timeout with diagnostics.
- Sits beside top in system benches and FPGA self-test builds; replaces hand-coded stop counters and ad-hoc WriteData checks.

Parameters:
- DW, 32, data and address width.
- DEPTH, 16, expected-store table entries (power of two, >=2).
- MAX_CYCLES, 100, watchdog limit in clock cycles while running.
- STRICT, 1, when 1 a store after the sequence completes is a failure.
- Derived: IW = $clog2(DEPTH), CW = $clog2(MAX_CYCLES+1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- exp_we  in  1  write one expected-table entry
- exp_idx  in  IW  table index to write
- exp_addr  in  DW  expected DataAdr
- exp_data  in  DW  expected WriteData
- exp_count  in  IW+1  number of entries to check, sampled on start
- start  in  1  begin a check run
- MemWrite  in  1  monitored store strobe
- DataAdr  in  DW  monitored address
- WriteData  in  DW  monitored data
- busy  out  1  state is RUN
- done  out  1  state is PASS, FAIL or TIMEOUT
- pass  out  1  state is PASS
- fail_code  out  3  0 none, 1 address mismatch, 2 data mismatch, 3 extra store, 4 timeout
- fail_index  out  IW+1  value of match_count when the failure occurred
- match_count  out  IW+1  stores matched in the current run
- cycle_count  out  CW  cycles spent in RUN

Behaviour:
- Reset (asynchronous): state IDLE, all outputs 0, table contents unchanged.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT.
- All outputs are registered and reflect the state after each clock edge.
- Table write: on an edge with exp_we=1 and state != RUN, table[exp_idx] <= {exp_addr, exp_data}. exp_we is ignored in RUN.
- start in IDLE/PASS/FAIL/TIMEOUT:
  - Next state RUN; latches exp_count; clears match_count, cycle_count, fail_code, fail_index.
  - start is ignored in RUN.
  - If exp_we and start are asserted together, the table write happens and the run starts; the new entry is visible from the first RUN cycle.
- RUN, each edge:
  - cycle_count increments (saturates at MAX_CYCLES).
  - If MemWrite=1, compare against table[match_count]:
    - DataAdr mismatch -> FAIL, code 1. Address takes priority when both fields mismatch.
    - Else WriteData mismatch -> FAIL, code 2.
    - Else match_count increments.
  - When match_count reaches the latched count (including on the matching edge itself), next state is PASS.
  - Latched count = 0 -> PASS one edge after start.
  - Comparisons on the start edge itself are not performed.
- Watchdog: if in RUN the incremented cycle_count equals MAX_CYCLES and the run is not completing on that edge, go to TIMEOUT, code 4.
  - Same-edge final match wins over timeout.
  - Same-edge mismatch wins over timeout.
- PASS: if STRICT=1 and MemWrite=1 -> FAIL, code 3, fail_index = match_count. With STRICT=0, stores in PASS are ignored.
- Terminal states hold all outputs until start or reset.
- MemWrite outside RUN/PASS is ignored.
- fail_index is captured once on entry to FAIL/TIMEOUT and never overwritten.
- Reset mid-run: immediate return to IDLE, no partial status retained.

Test Plan:
- Load 3 entries {100:7}, {104:3}, {108:5}, exp_count=3, start; drive those 3 stores at cycles 4, 9, 12 -> pass=1 one edge after the third store, match_count=3, fail_code=0.
- Same table; second store is {104:9} -> FAIL, fail_code=2, fail_index=1, busy=0, done=1.
- Same table; second store is {100:3} -> fail_code=1, fail_index=1. Also check a store with both address and data wrong reports code 1.
- exp_count=1, MAX_CYCLES=100, no MemWrite -> TIMEOUT at cycle_count=100, fail_code=4, fail_index=0. Variant: matching store on the 100th cycle -> PASS, not TIMEOUT.
- STRICT=1, after PASS drive MemWrite {200:1} -> fail_code=3, fail_index=3. With STRICT=0, pass stays 1.
- Assert reset asynchronously mid-RUN (between edges) -> all outputs 0 immediately; reload not required. start again with the same table -> run completes PASS. Also exp_count=0 start -> pass=1 after one edge.

Source files
------------

// File: rtl/mem_write_scoreboard.sv
// Monitor on the data-memory write port: checks an in-order list of expected
// stores from an internal table and runs a cycle watchdog while checking.
module mem_write_scoreboard #(
   parameter int unsigned DW         = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned MAX_CYCLES = 100,
   parameter int unsigned STRICT     = 1,
   localparam int unsigned IW        = $clog2(DEPTH),
   localparam int unsigned CW        = $clog2(MAX_CYCLES + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          exp_we,
   input  logic [IW-1:0] exp_idx,
   input  logic [DW-1:0] exp_addr,
   input  logic [DW-1:0] exp_data,
   input  logic [IW:0]   exp_count,
   input  logic          start,
   input  logic          MemWrite,
   input  logic [DW-1:0] DataAdr,
   input  logic [DW-1:0] WriteData,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [2:0]    fail_code,
   output logic [IW:0]   fail_index,
   output logic [IW:0]   match_count,
   output logic [CW-1:0] cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_PASS,
      S_FAIL,
      S_TIMEOUT
   } state_t;

   localparam logic [2:0] CODE_NONE    = 3'd0;
   localparam logic [2:0] CODE_ADDR    = 3'd1;
   localparam logic [2:0] CODE_DATA    = 3'd2;
   localparam logic [2:0] CODE_EXTRA   = 3'd3;
   localparam logic [2:0] CODE_TIMEOUT = 3'd4;
   localparam logic [CW-1:0] CYC_LIMIT = CW'(MAX_CYCLES);

   state_t        state, state_n;
   logic [IW:0]   count_q, count_n;
   logic [IW:0]   match_n, match_inc;
   logic [CW-1:0] cycle_n, cycle_inc;
   logic [2:0]    code_n;
   logic [IW:0]   index_n;
   logic [DW-1:0] entry_addr, entry_data;

   // Table has no reset so a reset mid-run does not require reloading.
   logic [DW-1:0] tab_addr [DEPTH];
   logic [DW-1:0] tab_data [DEPTH];

   always_ff @(posedge clk) begin
      if (exp_we && state != S_RUN) begin
         tab_addr[exp_idx] <= exp_addr;
         tab_data[exp_idx] <= exp_data;
      end
   end

   assign entry_addr = tab_addr[match_count[IW-1:0]];
   assign entry_data = tab_data[match_count[IW-1:0]];
   assign match_inc  = match_count + 1'b1;
   assign cycle_inc  = (cycle_count == CYC_LIMIT) ? cycle_count : cycle_count + 1'b1;

   always_comb begin
      state_n = state;
      count_n = count_q;
      match_n = match_count;
      cycle_n = cycle_count;
      code_n  = fail_code;
      index_n = fail_index;
      case (state)
         S_RUN: begin
            cycle_n = cycle_inc;
            // Mismatch and final match are resolved before the watchdog so both win over it.
            if (match_count == count_q) begin
               state_n = S_PASS;
            end else if (MemWrite && DataAdr != entry_addr) begin
               state_n = S_FAIL;
               code_n  = CODE_ADDR;
               index_n = match_count;
            end else if (MemWrite && WriteData != entry_data) begin
               state_n = S_FAIL;
               code_n  = CODE_DATA;
               index_n = match_count;
            end else if (MemWrite && match_inc == count_q) begin
               match_n = match_inc;
               state_n = S_PASS;
            end else begin
               if (MemWrite) match_n = match_inc;
               if (cycle_inc == CYC_LIMIT) begin
                  state_n = S_TIMEOUT;
                  code_n  = CODE_TIMEOUT;
                  index_n = match_n;
               end
            end
         end
         S_PASS: begin
            if (STRICT != 0 && MemWrite) begin
               state_n = S_FAIL;
               code_n  = CODE_EXTRA;
               index_n = match_count;
            end
         end
         default: ;
      endcase
      if (start && state != S_RUN) begin
         state_n = S_RUN;
         count_n = exp_count;
         match_n = '0;
         cycle_n = '0;
         code_n  = CODE_NONE;
         index_n = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         count_q     <= '0;
         match_count <= '0;
         cycle_count <= '0;
         fail_code   <= '0;
         fail_index  <= '0;
      end else begin
         state       <= state_n;
         count_q     <= count_n;
         match_count <= match_n;
         cycle_count <= cycle_n;
         fail_code   <= code_n;
         fail_index  <= index_n;
      end
   end

   assign busy = (state == S_RUN);
   assign pass = (state == S_PASS);
   assign done = (state == S_PASS) || (state == S_FAIL) || (state == S_TIMEOUT);

endmodule

// File: tb/tb_mem_write_scoreboard.sv
// Directed bench for mem_write_scoreboard; a STRICT=0 copy shares all inputs.
module tb_mem_write_scoreboard;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = 4;
   localparam int unsigned CW = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic          exp_we;
   logic [IW-1:0] exp_idx;
   logic [DW-1:0] exp_addr, exp_data;
   logic [IW:0]   exp_count;
   logic          start;
   logic          MemWrite;
   logic [DW-1:0] DataAdr, WriteData;

   logic          busy, done, pass;
   logic [2:0]    fail_code;
   logic [IW:0]   fail_index, match_count;
   logic [CW-1:0] cycle_count;

   logic          ns_busy, ns_done, ns_pass;
   logic [2:0]    ns_fail_code;
   logic [IW:0]   ns_fail_index, ns_match_count;
   logic [CW-1:0] ns_cycle_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_write_scoreboard #(.DW(32), .DEPTH(16), .MAX_CYCLES(100), .STRICT(1)) dut (
      .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx),
      .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count),
      .start(start), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
      .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
      .fail_index(fail_index), .match_count(match_count), .cycle_count(cycle_count)
   );

   mem_write_scoreboard #(.DW(32), .DEPTH(16), .MAX_CYCLES(100), .STRICT(0)) dut_ns (
      .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx),
      .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count),
      .start(start), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
      .busy(ns_busy), .done(ns_done), .pass(ns_pass), .fail_code(ns_fail_code),
      .fail_index(ns_fail_index), .match_count(ns_match_count), .cycle_count(ns_cycle_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic load3();
      exp_we = 1'b1;
      exp_idx = 4'd0; exp_addr = 100; exp_data = 7; tick();
      exp_idx = 4'd1; exp_addr = 104; exp_data = 3; tick();
      exp_idx = 4'd2; exp_addr = 108; exp_data = 5; tick();
      exp_we = 1'b0;
   endtask

   task automatic do_start(input logic [IW:0] n);
      exp_count = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic store(input logic [DW-1:0] a, input logic [DW-1:0] d);
      MemWrite = 1'b1; DataAdr = a; WriteData = d;
      tick();
      MemWrite = 1'b0;
   endtask

   // Status vector {busy, done, pass, fail_code}
   task automatic test_reset();
      reset = 1'b1; exp_we = 0; exp_idx = 0; exp_addr = 0; exp_data = 0;
      exp_count = 0; start = 0; MemWrite = 0; DataAdr = 0; WriteData = 0;
      idle(2);
      checks++;
      if ({busy, done, pass, fail_code, fail_index, match_count, cycle_count} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required all zero",
                  {busy, done, pass, fail_code, fail_index, match_count, cycle_count});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_pass_sequence();
      load3();
      do_start(3);
      idle(3); store(100, 7); idle(4); store(104, 3); idle(2);
      checks++;
      if ({busy, match_count} !== {1'b1, 5'd2}) begin
         errors++; $display("FAIL mid_run: got busy=%0d match=%0d required 1 2", busy, match_count);
      end
      store(108, 5);
      checks++;
      if ({busy, done, pass, fail_code} !== 6'b011_000) begin
         errors++; $display("FAIL pass_status: got %b required 011000", {busy, done, pass, fail_code});
      end
      checks++;
      if (match_count !== 5'd3) begin
         errors++; $display("FAIL pass_match: got %0d required 3", match_count);
      end
      checks++;
      if (cycle_count !== 7'd12) begin
         errors++; $display("FAIL pass_cycles: got %0d required 12", cycle_count);
      end
   endtask

   task automatic test_data_mismatch();
      do_start(3);
      store(100, 7); store(104, 9);
      checks++;
      if ({busy, done, pass, fail_code} !== 6'b010_010) begin
         errors++; $display("FAIL data_status: got %b required 010010", {busy, done, pass, fail_code});
      end
      checks++;
      if (fail_index !== 5'd1) begin
         errors++; $display("FAIL data_index: got %0d required 1", fail_index);
      end
   endtask

   task automatic test_addr_mismatch();
      do_start(3);
      store(100, 7); store(100, 3);
      checks++;
      if ({fail_code, fail_index} !== {3'd1, 5'd1}) begin
         errors++; $display("FAIL addr_code: got code=%0d idx=%0d required 1 1", fail_code, fail_index);
      end
      do_start(3);
      store(999, 999);
      checks++;
      if ({done, fail_code, fail_index} !== {1'b1, 3'd1, 5'd0}) begin
         errors++; $display("FAIL both_wrong: got done=%0d code=%0d idx=%0d required 1 1 0", done, fail_code, fail_index);
      end
      idle(2); store(100, 7);
      checks++;
      if ({done, fail_code, fail_index, match_count} !== {1'b1, 3'd1, 5'd0, 5'd0}) begin
         errors++; $display("FAIL fail_hold: got done=%0d code=%0d idx=%0d match=%0d required 1 1 0 0",
                            done, fail_code, fail_index, match_count);
      end
   endtask

   task automatic test_strict();
      do_start(3);
      store(100, 7); store(104, 3); store(108, 5);
      checks++;
      if ({pass, ns_pass} !== 2'b11) begin
         errors++; $display("FAIL b2b_pass: got %b required 11", {pass, ns_pass});
      end
      store(200, 1);
      checks++;
      if ({done, pass, fail_code, fail_index} !== {1'b1, 1'b0, 3'd3, 5'd3}) begin
         errors++; $display("FAIL strict_extra: got pass=%0d code=%0d idx=%0d required 0 3 3", pass, fail_code, fail_index);
      end
      checks++;
      if ({ns_pass, ns_fail_code} !== {1'b1, 3'd0}) begin
         errors++; $display("FAIL nonstrict_extra: got pass=%0d code=%0d required 1 0", ns_pass, ns_fail_code);
      end
   endtask

   task automatic test_timeout();
      do_start(1);
      idle(99);
      checks++;
      if ({busy, cycle_count} !== {1'b1, 7'd99}) begin
         errors++; $display("FAIL pre_timeout: got busy=%0d cycles=%0d required 1 99", busy, cycle_count);
      end
      tick();
      checks++;
      if ({busy, done, pass, fail_code, fail_index} !== {6'b010_100, 5'd0}) begin
         errors++; $display("FAIL timeout_status: got %b required 01010000000", {busy, done, pass, fail_code, fail_index});
      end
      idle(2);
      checks++;
      if (cycle_count !== 7'd100) begin
         errors++; $display("FAIL timeout_cycles: got %0d required 100", cycle_count);
      end
      do_start(1);
      idle(99); store(100, 7);
      checks++;
      if ({pass, fail_code, cycle_count} !== {1'b1, 3'd0, 7'd100}) begin
         errors++; $display("FAIL last_cycle_match: got pass=%0d code=%0d cycles=%0d required 1 0 100",
                            pass, fail_code, cycle_count);
      end
   endtask

   task automatic test_async_reset();
      do_start(3);
      store(100, 7); idle(2);
      #3 reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, pass, fail_code, fail_index, match_count, cycle_count} !== '0) begin
         errors++; $display("FAIL async_reset: got %b required all zero",
                            {busy, done, pass, fail_code, fail_index, match_count, cycle_count});
      end
      #2 reset = 1'b0;
      tick();
      do_start(3);
      store(100, 7); store(104, 3); store(108, 5);
      checks++;
      if ({pass, match_count} !== {1'b1, 5'd3}) begin
         errors++; $display("FAIL rerun_after_reset: got pass=%0d match=%0d required 1 3", pass, match_count);
      end
      do_start(0);
      checks++;
      if ({busy, pass} !== 2'b10) begin
         errors++; $display("FAIL zero_count_run: got busy=%0d pass=%0d required 1 0", busy, pass);
      end
      tick();
      checks++;
      if ({busy, pass, match_count} !== {2'b01, 5'd0}) begin
         errors++; $display("FAIL zero_count_pass: got busy=%0d pass=%0d match=%0d required 0 1 0", busy, pass, match_count);
      end
   endtask

   task automatic test_table_write();
      do_start(3);
      exp_we = 1'b1; exp_idx = 4'd1; exp_addr = 500; exp_data = 500;
      store(100, 7);
      exp_we = 1'b0;
      store(104, 3); store(108, 5);
      checks++;
      if ({pass, fail_code} !== {1'b1, 3'd0}) begin
         errors++; $display("FAIL we_ignored_in_run: got pass=%0d code=%0d required 1 0", pass, fail_code);
      end
      exp_we = 1'b1; exp_idx = 4'd0; exp_addr = 300; exp_data = 30;
      do_start(1);
      exp_we = 1'b0;
      store(300, 30);
      checks++;
      if ({pass, fail_code, match_count} !== {1'b1, 3'd0, 5'd1}) begin
         errors++; $display("FAIL we_with_start: got pass=%0d code=%0d match=%0d required 1 0 1",
                            pass, fail_code, match_count);
      end
   endtask

   initial begin
      test_reset();
      test_pass_sequence();
      test_data_mismatch();
      test_addr_mismatch();
      test_strict();
      test_timeout();
      test_async_reset();
      test_table_write();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running required finished");
      $fatal(1, "bench time limit");
   end
endmodule
